// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and the default bit period.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Clock cycles per serial bit; the transmitter and receiver must agree on it.
  localparam int CLKS_PER_BIT_DEF = 100;

  // Width of the per-bit cycle counter.
  localparam int CNT_W = 16;

  // Receiver frame states, encoded upward from zero.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer bringing an asynchronous single-bit input into the clk domain.
// Latency: 2 clk cycles from input change to q_o.
// Backpressure: none; samples every cycle.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift, both stages forced to the line's idle level in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and break handling.
// Latency: valid rises 3 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start-bit falling edge.
// Backpressure: none; valid is a one-cycle pulse and data holds until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_sync;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] clk_count_q, clk_count_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;

  logic half_hit;
  logic bit_hit;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_sync)
  );

  assign half_hit = (clk_count_q == HALF_LAST);
  assign bit_hit  = (clk_count_q == BIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; outputs are registered so pulses are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_count_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_count_q <= clk_count_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state: frame sequencing decided only at the mid-bit sample points.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_sync) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at its mid-point was a glitch.
        if (half_hit) state_d = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_hit && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leaving at the stop mid-point lets a back-to-back start bit be caught.
        if (bit_hit) state_d = rx_sync ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        // Hold here through a break so it reports only one framing error.
        if (rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values: bit counter, shift register, result pulses.
  always_comb begin
    clk_count_d = clk_count_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_count_d = '0;
        bit_idx_d   = '0;
      end
      ST_START: begin
        if (half_hit) begin
          clk_count_d = '0;
          bit_idx_d   = '0;
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          shift_d[bit_idx_q] = rx_sync;
          clk_count_d        = '0;
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          clk_count_d = '0;
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        clk_count_d = '0;
      end
      default: begin
        clk_count_d = '0;
        bit_idx_d   = '0;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
